// File: rtl/duty_ramp_pkg.sv
// Shared types and defaults for the duty-cycle slew limiter.
package duty_ramp_pkg;

   localparam int DUTY_W_DEF = 8;
   localparam int DIV_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } state_t;

   // A zero step would stall the ramp forever, so it is promoted to one.
   function automatic logic [3:0] eff_step(input logic [3:0] s);
      return (s == 4'd0) ? 4'd1 : s;
   endfunction

endpackage

// File: rtl/duty_ramp_if.sv
// Register-bank side and PWM side signals of duty_ramp.
// busy/done exist only when DUTY_RAMP_STATUS_EN is defined.
interface duty_ramp_if #(
   parameter int DUTY_W = duty_ramp_pkg::DUTY_W_DEF,
   parameter int DIV_W  = duty_ramp_pkg::DIV_W_DEF
) ();

   logic [DUTY_W-1:0] target_duty;
   logic [3:0]        step;
   logic [DIV_W-1:0]  rate_div;
   logic              ramp_en;
   logic [DUTY_W-1:0] duty_out;
`ifdef DUTY_RAMP_STATUS_EN
   logic              busy;
   logic              done;

   modport master (output target_duty, step, rate_div, ramp_en,
                   input  duty_out, busy, done);
   modport slave  (input  target_duty, step, rate_div, ramp_en,
                   output duty_out, busy, done);
`else
   modport master (output target_duty, step, rate_div, ramp_en,
                   input  duty_out);
   modport slave  (input  target_duty, step, rate_div, ramp_en,
                   output duty_out);
`endif

endinterface

// File: rtl/duty_ramp_tick.sv
// Ramp tick divider: tick fires when cnt has reached rate_div, giving one tick
// every rate_div+1 cycles; compared live so a lowered divider acts at once.
module ramp_tick #(
   parameter int DIV_W = duty_ramp_pkg::DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [DIV_W-1:0] rate_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic             wrap;

   assign wrap = (cnt >= rate_div);
   assign tick = !clear && wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/duty_ramp.sv
// Slews the PWM duty toward the programmed target in bounded steps.
// Optional busy/done status ports are built when DUTY_RAMP_STATUS_EN is defined.
module duty_ramp
   import duty_ramp_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   duty_ramp_if.slave bus
);

   state_t            state, state_nxt;
   logic [DUTY_W-1:0] duty_q, duty_nxt;
   logic              tick, tick_clr;

   logic [DUTY_W:0]   tgt_x, duty_x, stp_x, gap, delta, sum;
   logic              going_up;

   assign tgt_x    = {1'b0, bus.target_duty};
   assign duty_x   = {1'b0, duty_q};
   assign stp_x    = {{(DUTY_W-3){1'b0}}, eff_step(bus.step)};
   assign going_up = (state == UP);

   // The divider runs only while ramping; IDLE keeps it at zero so every
   // fresh ramp starts its first tick period from scratch.
   assign tick_clr = !bus.ramp_en || (state == IDLE);

   ramp_tick #(.DIV_W(DIV_W)) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (tick_clr),
      .rate_div (bus.rate_div),
      .tick     (tick)
   );

   always_comb begin
      state_nxt = state;
      duty_nxt  = duty_q;
      gap       = '0;
      delta     = '0;
      sum       = duty_x;
      if (!bus.ramp_en) begin
         state_nxt = IDLE;
         duty_nxt  = bus.target_duty;
      end else begin
         case (state)
            IDLE: begin
               if (tgt_x > duty_x) begin
                  state_nxt = UP;
               end else if (tgt_x < duty_x) begin
                  state_nxt = DOWN;
               end
            end
            UP, DOWN: begin
               if (tgt_x == duty_x) begin
                  state_nxt = IDLE;
               end else if (going_up != (tgt_x > duty_x)) begin
                  // Target crossed behind us: turn around, step on a later tick.
                  state_nxt = going_up ? DOWN : UP;
               end else if (tick) begin
                  gap   = going_up ? (tgt_x - duty_x) : (duty_x - tgt_x);
                  delta = (stp_x < gap) ? stp_x : gap;
                  sum   = going_up ? (duty_x + delta) : (duty_x - delta);
                  if (sum[DUTY_W]) begin
                     duty_nxt = going_up ? '1 : '0;
                  end else begin
                     duty_nxt = sum[DUTY_W-1:0];
                  end
                  if (delta == gap) begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         duty_q <= '0;
      end else begin
         state  <= state_nxt;
         duty_q <= duty_nxt;
      end
   end

   assign bus.duty_out = duty_q;

`ifdef DUTY_RAMP_STATUS_EN
   logic done_q;
   logic reached;

   // Leaving a ramp state with the enable high only happens on arrival.
   assign reached = (state != IDLE) && bus.ramp_en && (state_nxt == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= reached;
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;
`endif

endmodule
